// File: rtl/dfe_pkg.sv
// ============================================================================
//  Module   : dfe_pkg
//  Brief    : Shared constants, state encodings and helpers for the DFE
//             output serializer slice.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dfe_pkg;

  // ADC resolution used when nothing else is specified
  localparam int BW_DEFAULT    = 6;

  // DFE output word width: ADC bits plus the equaliser's growth bits
  localparam int W             = BW_DEFAULT + 15;

  // Buffer depth in words (power of two, at least 2)
  localparam int DEPTH_DEFAULT = 8;

  // Serializer states
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  // Word width for an arbitrary ADC resolution
  function automatic int word_width(input int bw);
    return bw + 15;
  endfunction

endpackage : dfe_pkg

`default_nettype wire

// File: rtl/dfe_out_serializer_if.sv
// ============================================================================
//  Module   : dfe_out_serializer_if
//  Brief    : Word-in / serial-out bundle of the DFE output serializer.
//             The slave side is the serializer, the master side feeds it.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dfe_out_serializer_if
  import dfe_pkg::*;
#(
  parameter int BW    = BW_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) ();

  logic                       ENABLE;
  logic signed [BW+14:0]      IN;
  logic                       IN_VALID;
  logic                       SDO;
  logic                       SFRAME;
  logic                       SBUSY;
  logic                       OVF;
  logic [$clog2(DEPTH):0]     LEVEL;

  modport master (
    output ENABLE, IN, IN_VALID,
    input  SDO, SFRAME, SBUSY, OVF, LEVEL
  );

  modport slave (
    input  ENABLE, IN, IN_VALID,
    output SDO, SFRAME, SBUSY, OVF, LEVEL
  );

endinterface : dfe_out_serializer_if

`default_nettype wire

// File: rtl/dfe_sync_fifo.sv
// ============================================================================
//  Module   : dfe_sync_fifo
//  Brief    : Single-clock word buffer with simultaneous push/pop support.
//             The caller qualifies push and pop; a push while full is only
//             issued together with a pop.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dfe_sync_fifo
  import dfe_pkg::*;
#(
  parameter int WIDTH = W,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     push,
  input  wire logic                     pop,
  input  wire logic [WIDTH-1:0]         din,
  output logic      [WIDTH-1:0]         dout,
  output logic                          full,
  output logic                          empty,
  output logic      [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q,  level_d;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer/occupancy registers, cleared by the asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care after reset since level is 0
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule : dfe_sync_fifo

`default_nettype wire

// File: rtl/dfe_out_serializer.sv
// ============================================================================
//  Module   : dfe_out_serializer
//  Brief    : Buffers DFE output words and shifts them out MSB first on a
//             single serial line with a frame strobe on each MSB.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dfe_out_serializer
  import dfe_pkg::*;
#(
  parameter int BW    = BW_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  wire logic           CLK,
  input  wire logic           RES,
  dfe_out_serializer_if.slave bus
);

  localparam int WW = word_width(BW);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(WW);
  localparam logic [CW-1:0] C_LAST = CW'(WW - 1);

  ser_state_e       state_q, state_d;
  logic [WW-1:0]    shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             sframe_q, sframe_d;
  logic             ovf_q,   ovf_d;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WW-1:0]    fifo_dout;
  logic [LW-1:0]    fifo_level;
  logic             can_start;

  // A new frame may begin only with a buffered word and ENABLE high
  assign can_start = bus.ENABLE && !fifo_empty;

  dfe_sync_fifo #(
    .WIDTH (WW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RES),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ($unsigned(bus.IN)),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Serializer next state: load on start/frame end, otherwise shift left
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    sframe_d = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (can_start) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_dout;
          cnt_d    = '0;
          sframe_d = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != C_LAST) begin
          shreg_d = {shreg_q[WW-2:0], 1'b0};
          cnt_d   = cnt_q + CW'(1);
        end else if (can_start) begin
          // Back-to-back frame: next MSB follows the LSB with no gap
          fifo_pop = 1'b1;
          shreg_d  = fifo_dout;
          cnt_d    = '0;
          sframe_d = 1'b1;
        end else begin
          // Clearing the shifter forces SDO low while idle
          shreg_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        shreg_d = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Write acceptance and sticky overflow; a pop frees the slot a full push needs
  always_comb begin
    fifo_push = bus.IN_VALID && bus.ENABLE && (!fifo_full || fifo_pop);
    ovf_d     = ovf_q || (bus.IN_VALID && bus.ENABLE && fifo_full && !fifo_pop);
  end

  // Serializer registers; reset aborts any frame in progress immediately
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      sframe_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      sframe_q <= sframe_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.SDO    = shreg_q[WW-1];
  assign bus.SFRAME = sframe_q;
  assign bus.SBUSY  = (state_q == SHIFT);
  assign bus.OVF    = ovf_q;
  assign bus.LEVEL  = fifo_level;

endmodule : dfe_out_serializer

`default_nettype wire

// File: tb/tb_dfe_out_serializer.sv
// ============================================================================
//  Module   : tb_dfe_out_serializer
//  Brief    : Self-checking bench for dfe_out_serializer: directed scenarios
//             plus random traffic, queue-based reference model, scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dfe_out_serializer;

  localparam int BW    = 6;
  localparam int DEPTH = 8;
  localparam int WW    = BW + 15;

  logic CLK = 1'b0;
  logic RES = 1'b1;

  always #5 CLK = ~CLK;

  dfe_out_serializer_if #(.BW(BW), .DEPTH(DEPTH)) bus ();

  dfe_out_serializer #(.BW(BW), .DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RES (RES),
    .bus (bus)
  );

  // ---------------- reference model state ----------------
  logic [WW-1:0] m_q[$];     // words sitting in the buffer
  int            m_rem  = 0; // bits of current word still to appear (incl. current)
  bit            m_frame = 0;
  bit            m_ovf  = 0;
  logic [WW-1:0] exp_q[$];   // scoreboard: accepted words in output order

  int n_cmp = 0;
  int n_err = 0;

  // monitor state
  bit            collecting = 0;
  int            nbits = 0;
  logic [WW-1:0] mon_acc = '0;
  logic [WW-1:0] mon_exp;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference model: buffer as a queue, serializer as a remaining-bit count
  always @(posedge CLK) begin : model
    bit pop_e, acc_e;
    if (RES) begin
      m_q.delete();
      m_rem   = 0;
      m_frame = 0;
      m_ovf   = 0;
    end else begin
      pop_e = bus.ENABLE && (m_q.size() > 0) && (m_rem <= 1);
      acc_e = bus.IN_VALID && bus.ENABLE && ((m_q.size() < DEPTH) || pop_e);
      if (bus.IN_VALID && bus.ENABLE && !acc_e) m_ovf = 1;
      if (pop_e) begin
        void'(m_q.pop_front());
        m_rem   = WW;
        m_frame = 1;
      end else begin
        if (m_rem > 0) m_rem--;
        m_frame = 0;
      end
      if (acc_e) begin
        m_q.push_back(bus.IN);
        exp_q.push_back(bus.IN);
      end
    end
  end

  // Monitor: per-cycle status checks and word reassembly against scoreboard
  always @(negedge CLK) begin
    if (RES) begin
      collecting = 0;
    end else begin
      check("level",  32'(bus.LEVEL),  32'(m_q.size()));
      check("ovf",    32'(bus.OVF),    32'(m_ovf));
      check("sbusy",  32'(bus.SBUSY),  32'(m_rem > 0));
      check("sframe", 32'(bus.SFRAME), 32'(m_frame));
      if (bus.SFRAME) begin
        if (collecting) check("truncated_word_bits", 32'(nbits), 32'(WW));
        collecting = 1;
        nbits      = 0;
        mon_acc    = '0;
      end
      if (collecting) begin
        mon_acc = {mon_acc[WW-2:0], bus.SDO};
        nbits++;
        if (nbits == WW) begin
          collecting = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_word", 32'(mon_acc), 32'hFFFF_FFFF);
          end else begin
            mon_exp = exp_q.pop_front();
            check("word", 32'(mon_acc), 32'(mon_exp));
          end
        end
      end else begin
        check("idle_sdo", 32'(bus.SDO), 32'd0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit v, input logic [WW-1:0] d);
    bus.IN_VALID = v;
    bus.IN       = d;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_sdo"},    32'(bus.SDO),    32'd0);
    check({tag, "_sbusy"},  32'(bus.SBUSY),  32'd0);
    check({tag, "_sframe"}, 32'(bus.SFRAME), 32'd0);
    check({tag, "_level"},  32'(bus.LEVEL),  32'd0);
    check({tag, "_ovf"},    32'(bus.OVF),    32'd0);
  endtask

  // Asynchronous reset pulse, called #1 after an edge; outputs must clear at once
  task automatic do_reset();
    RES = 1'b1;
    m_q.delete();
    m_rem   = 0;
    m_frame = 0;
    m_ovf   = 0;
    exp_q.delete();
    collecting = 0;
    drive(0, '0);
    #1;
    check_zero_outputs("async_rst");
    tick();
    RES = 1'b0;
  endtask

  task automatic wait_rem(input int target, input int budget);
    int b = budget;
    while (m_rem != target && b > 0) begin
      tick();
      b--;
    end
    if (m_rem != target) check("timeout_wait_rem", 32'(m_rem), 32'(target));
  endtask

  task automatic wait_idle(input int budget);
    int b = budget;
    while ((m_q.size() != 0 || m_rem != 0) && b > 0) begin
      tick();
      b--;
    end
    if (m_q.size() != 0 || m_rem != 0) check("timeout_wait_idle", 32'(m_q.size() + m_rem), 32'd0);
    tick();
  endtask

  // ---------------- scenarios ----------------
  initial begin
    bus.ENABLE   = 1'b0;
    bus.IN_VALID = 1'b0;
    bus.IN       = '0;
    RES          = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_zero_outputs("reset_state");
    RES        = 1'b0;
    bus.ENABLE = 1'b1;
    tick();

    // Single word with fixed latency: MSB after k+1, LSB after k+W
    drive(1, 21'h0ABCDE);
    tick();                       // edge k
    drive(0, '0);
    tick();                       // edge k+1
    check("lat_sframe", 32'(bus.SFRAME), 32'd1);
    check("lat_msb",    32'(bus.SDO),    32'd0);
    repeat (WW - 1) tick();       // edge k+W
    check("lat_lsb_busy", 32'(bus.SBUSY), 32'd1);
    check("lat_lsb_bit",  32'(bus.SDO),   32'd0);
    tick();
    check("single_done_busy", 32'(bus.SBUSY), 32'd0);
    wait_idle(50);

    // Back-to-back: 42 contiguous bits, frames at bit 0 and bit 21
    drive(1, 21'h1FFFFF);
    tick();
    drive(0, '0);
    tick();
    drive(1, 21'h100000);
    tick();
    drive(0, '0);
    wait_idle(100);

    // Overflow: 10 consecutive strobes into an 8-deep buffer
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1, WW'($urandom));
      tick();
    end
    drive(0, '0);
    check("ovf_peak_level", 32'(bus.LEVEL), 32'd8);
    check("ovf_set",        32'(bus.OVF),   32'd1);
    wait_idle(400);
    check("ovf_sticky", 32'(bus.OVF), 32'd1);
    do_reset();
    check("ovf_cleared", 32'(bus.OVF), 32'd0);

    // Full buffer with a push on the frame-end pop edge
    for (int i = 0; i < 9; i++) begin
      drive(1, WW'($urandom));
      tick();
    end
    drive(0, '0);
    check("full_level", 32'(bus.LEVEL), 32'd8);
    wait_rem(1, 50);
    drive(1, 21'h155555);
    tick();
    drive(0, '0);
    check("fullpop_level", 32'(bus.LEVEL), 32'd8);
    check("fullpop_ovf",   32'(bus.OVF),   32'd0);
    wait_idle(400);

    // ENABLE dropped at bit 5 with three words queued
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, WW'($urandom));
      tick();
    end
    drive(0, '0);
    wait_rem(WW - 5, 50);
    bus.ENABLE = 1'b0;
    repeat (WW) tick();
    check("endrop_busy",  32'(bus.SBUSY), 32'd0);
    check("endrop_level", 32'(bus.LEVEL), 32'd3);
    bus.ENABLE = 1'b1;
    wait_idle(200);

    // Reset at bit 10 of a frame: nothing may come out afterwards
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, WW'($urandom));
      tick();
    end
    drive(0, '0);
    wait_rem(WW - 10, 50);
    do_reset();
    repeat (30) tick();
    check("post_rst_level", 32'(bus.LEVEL), 32'd0);

    // Random traffic in phases of differing write density
    for (int ph = 0; ph < 4; ph++) begin
      do_reset();
      for (int c = 0; c < 600; c++) begin
        bus.ENABLE = ($urandom_range(0, 19) != 0);
        case (ph)
          0:       drive($urandom_range(0, 29) == 0, WW'($urandom));
          1:       drive($urandom_range(0, 19) == 0, WW'($urandom));
          2:       drive($urandom_range(0, 15) < 1 + (c / 150), WW'($urandom));
          default: drive($urandom_range(0, 3) == 0, WW'($urandom));
        endcase
        tick();
      end
      drive(0, '0);
      bus.ENABLE = 1'b1;
      wait_idle(400);
      check("leftover_words", 32'(exp_q.size()), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_dfe_out_serializer

`default_nettype wire
